bypass_pipeline: RTL and testbench

BYPASS_PIPELINE -- requirements
Module: bypass_pipeline

---
 rtl/bypass_pipeline.sv | 212 +++++++++++++++++++++
 tb/tb_bypass_pipeline.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bypass_pipeline.sv
// ---------------------------------------------------------------------------
// bypass_pipeline
//
// Tracks the instructions in flight after issue (EX, MEM, ..., WB) and
// resolves the source operands of the instruction sitting in ID. Every
// cycle each entry moves one stage older, and the WB entry retires
// through the register-file write port.
//
// Optional feature, selected by the macro BYPASS_PIPELINE_BYPASS_EN:
//   defined   - operands are forwarded from the youngest matching
//               in-flight entry when its result is available; ID stalls
//               only when that youngest producer has no result yet.
//   undefined - no forwarding; any in-flight writer of a source register
//               stalls ID, and operands always come from the register file.
//
// Parameters
//   XLEN   operand / result width
//   NRD    number of operand read ports
//   DEPTH  number of in-flight entries after issue (legal range 2..8);
//          e[0] is EX, e[1] is MEM, e[DEPTH-1] is WB
//
// Ports
//   clk_i          clock, all state changes on the rising edge
//   reset_i        synchronous, active-high reset
//   issue_valid_i  ID presents an instruction this cycle
//   issue_we_i     that instruction writes a destination register
//   issue_rd_i     its destination register index
//   issue_rs_i     source indices, port p at [5p+4:5p]
//   rf_data_i      raw register-file read data, port p at [p*XLEN +: XLEN]
//   res_valid_i    per-entry "result produced this cycle"
//   res_data_i     per-entry result data, entry k at [k*XLEN +: XLEN]
//   flush_i        kill the ID instruction and the EX entry
//   opnd_o         resolved operand per read port
//   stall_o        ID must hold; the issue is not accepted
//   wb_valid_o     register-file write enable
//   wb_rd_o        register-file write index (zero when not writing)
//   wb_data_o      register-file write data (zero when not writing)
//   err_o          sticky: an entry reached WB without its result
// ---------------------------------------------------------------------------
module bypass_pipeline #(
  parameter int XLEN  = 32,
  parameter int NRD   = 2,
  parameter int DEPTH = 3
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  issue_valid_i,
  input  logic                  issue_we_i,
  input  logic [4:0]            issue_rd_i,
  input  logic [NRD*5-1:0]      issue_rs_i,
  input  logic [NRD*XLEN-1:0]   rf_data_i,
  input  logic [DEPTH-1:0]      res_valid_i,
  input  logic [DEPTH*XLEN-1:0] res_data_i,
  input  logic                  flush_i,
  output logic [NRD*XLEN-1:0]   opnd_o,
  output logic                  stall_o,
  output logic                  wb_valid_o,
  output logic [4:0]            wb_rd_o,
  output logic [XLEN-1:0]       wb_data_o,
  output logic                  err_o
);

  typedef struct packed {
    logic            valid;
    logic            we;
    logic [4:0]      rd;
    logic            ready;
    logic [XLEN-1:0] data;
  } entry_t;

  entry_t e_q [DEPTH];
  entry_t e_d [DEPTH];

  logic                      err_q;
  logic                      err_set;
  logic [NRD-1:0][DEPTH-1:0] match;
  logic [NRD-1:0]            port_stall;

  // Which in-flight entries write the register each read port asks for.
  // x0 never matches, so a write to x0 can never be forwarded or stall.
  always_comb begin
    match = '0;
    for (int p = 0; p < NRD; p++) begin
      for (int k = 0; k < DEPTH; k++) begin
        match[p][k] = e_q[k].valid && e_q[k].we &&
                      (e_q[k].rd == issue_rs_i[5*p +: 5]) &&
                      (issue_rs_i[5*p +: 5] != 5'd0);
      end
    end
  end

`ifdef BYPASS_PIPELINE_BYPASS_EN
  logic [NRD-1:0]            win_any;
  logic [NRD-1:0]            win_ready;
  logic [NRD-1:0][XLEN-1:0]  win_data;

  // Pick the youngest matching producer per port. Scanning from the oldest
  // entry towards e[0] lets the younger match overwrite, so the lowest k
  // wins even when an older entry already has its result. A result
  // arriving this cycle takes precedence over the stored data, since it
  // is the newest value for that entry.
  always_comb begin
    win_any    = '0;
    win_ready  = '0;
    win_data   = '0;
    opnd_o     = '0;
    port_stall = '0;
    for (int p = 0; p < NRD; p++) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (match[p][k]) begin
          win_any[p]   = 1'b1;
          win_ready[p] = e_q[k].ready || res_valid_i[k];
          win_data[p]  = res_valid_i[k] ? res_data_i[k*XLEN +: XLEN]
                                        : e_q[k].data;
        end
      end
      if (issue_rs_i[5*p +: 5] == 5'd0) begin
        opnd_o[p*XLEN +: XLEN] = '0;
      end else if (win_any[p] && win_ready[p]) begin
        opnd_o[p*XLEN +: XLEN] = win_data[p];
      end else begin
        opnd_o[p*XLEN +: XLEN] = rf_data_i[p*XLEN +: XLEN];
      end
      port_stall[p] = win_any[p] && !win_ready[p];
    end
  end
`else
  // Without forwarding every pending writer of a source register blocks
  // ID until it has retired, and the register file is the only source.
  always_comb begin
    opnd_o     = '0;
    port_stall = '0;
    for (int p = 0; p < NRD; p++) begin
      port_stall[p] = |match[p];
      if (issue_rs_i[5*p +: 5] == 5'd0) begin
        opnd_o[p*XLEN +: XLEN] = '0;
      end else begin
        opnd_o[p*XLEN +: XLEN] = rf_data_i[p*XLEN +: XLEN];
      end
    end
  end
`endif

  // A hazard only matters when there is actually an instruction in ID.
  assign stall_o = issue_valid_i && (|port_stall);

  // Register-file write port from the WB entry. A result arriving in the
  // WB cycle itself is written straight through.
  always_comb begin
    wb_valid_o = e_q[DEPTH-1].valid && e_q[DEPTH-1].we &&
                 (e_q[DEPTH-1].rd != 5'd0) &&
                 (e_q[DEPTH-1].ready || res_valid_i[DEPTH-1]);
    wb_rd_o    = '0;
    wb_data_o  = '0;
    if (wb_valid_o) begin
      wb_rd_o   = e_q[DEPTH-1].rd;
      wb_data_o = res_valid_i[DEPTH-1] ? res_data_i[(DEPTH-1)*XLEN +: XLEN]
                                       : e_q[DEPTH-1].data;
    end
  end

  // A writer leaving WB with no result at all is a protocol violation by
  // the execution units; it is flagged and nothing is written.
  assign err_set = e_q[DEPTH-1].valid && e_q[DEPTH-1].we &&
                   !e_q[DEPTH-1].ready && !res_valid_i[DEPTH-1];

  // Next-state of the shift chain: each entry moves one stage older and
  // picks up any result produced for it this cycle. e[0] takes the ID
  // instruction only when it is really accepted; flush kills both the ID
  // instruction and whatever was in EX, leaving older stages alone.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      e_d[k] = '0;
    end
    for (int k = 1; k < DEPTH; k++) begin
      e_d[k] = e_q[k-1];
      if (e_q[k-1].valid && res_valid_i[k-1]) begin
        e_d[k].ready = 1'b1;
        e_d[k].data  = res_data_i[(k-1)*XLEN +: XLEN];
      end
    end
    if (issue_valid_i && !stall_o && !flush_i) begin
      e_d[0].valid = 1'b1;
      e_d[0].we    = issue_we_i;
      e_d[0].rd    = issue_rd_i;
    end
    if (flush_i) begin
      e_d[1] = '0;
    end
  end

  // Pipeline state and the sticky error flag. Reset outranks flush and
  // issue because it clears everything regardless of them.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        e_q[k] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        e_q[k] <= e_d[k];
      end
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_bypass_pipeline.sv
// ---------------------------------------------------------------------------
// tb_bypass_pipeline
//
// Self-checking bench for bypass_pipeline. A behavioural model keeps the
// in-flight instructions as a list of records tagged with their age in
// cycles since issue, and derives operands, stall, write-back and error
// from those records every cycle. Directed sequences pin the model with
// hand-computed literals, then a randomized run exercises hazards,
// flushes, missing results and resets.
// ---------------------------------------------------------------------------
module tb_bypass_pipeline;

  localparam int XLEN  = 32;
  localparam int NRD   = 2;
  localparam int DEPTH = 3;

  logic                  clk = 1'b0;
  logic                  reset_i;
  logic                  issue_valid_i;
  logic                  issue_we_i;
  logic [4:0]            issue_rd_i;
  logic [NRD*5-1:0]      issue_rs_i;
  logic [NRD*XLEN-1:0]   rf_data_i;
  logic [DEPTH-1:0]      res_valid_i;
  logic [DEPTH*XLEN-1:0] res_data_i;
  logic                  flush_i;
  logic [NRD*XLEN-1:0]   opnd_o;
  logic                  stall_o;
  logic                  wb_valid_o;
  logic [4:0]            wb_rd_o;
  logic [XLEN-1:0]       wb_data_o;
  logic                  err_o;

  always #5 clk = ~clk;

  bypass_pipeline #(.XLEN(XLEN), .NRD(NRD), .DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .issue_valid_i(issue_valid_i),
    .issue_we_i   (issue_we_i),
    .issue_rd_i   (issue_rd_i),
    .issue_rs_i   (issue_rs_i),
    .rf_data_i    (rf_data_i),
    .res_valid_i  (res_valid_i),
    .res_data_i   (res_data_i),
    .flush_i      (flush_i),
    .opnd_o       (opnd_o),
    .stall_o      (stall_o),
    .wb_valid_o   (wb_valid_o),
    .wb_rd_o      (wb_rd_o),
    .wb_data_o    (wb_data_o),
    .err_o        (err_o)
  );

  int tests    = 0;
  int failures = 0;

  // One in-flight instruction; age 0 is EX, age DEPTH-1 is WB.
  typedef struct {
    int            age;
    bit            we;
    bit [4:0]      rd;
    bit            ready;
    bit [XLEN-1:0] data;
  } inst_t;

  inst_t         inflight[$];
  bit            m_err;
  bit [XLEN-1:0] exp_opnd [NRD];
  bit            exp_def  [NRD];
  bit            exp_stall;
  bit            exp_wb_valid;
  bit [4:0]      exp_wb_rd;
  bit [XLEN-1:0] exp_wb_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // What the outputs must be right now, from the in-flight list and inputs.
  function automatic void modelOutputs();
    bit need = 0;
    for (int p = 0; p < NRD; p++) begin
      bit [4:0] rs = issue_rs_i[5*p +: 5];
      int best = -1;
      foreach (inflight[i]) begin
        if (rs != 0 && inflight[i].we && inflight[i].rd == rs &&
            (best < 0 || inflight[i].age < inflight[best].age)) best = i;
      end
      exp_def[p]  = 1;
      exp_opnd[p] = (rs == 0) ? '0 : rf_data_i[p*XLEN +: XLEN];
`ifdef BYPASS_PIPELINE_BYPASS_EN
      if (best >= 0) begin
        if (res_valid_i[inflight[best].age])
          exp_opnd[p] = res_data_i[inflight[best].age*XLEN +: XLEN];
        else if (inflight[best].ready)
          exp_opnd[p] = inflight[best].data;
        else begin
          need       = 1;
          exp_def[p] = 0;
        end
      end
`else
      if (best >= 0) need = 1;
`endif
    end
    exp_stall    = issue_valid_i && need;
    exp_wb_valid = 0;
    exp_wb_rd    = 0;
    exp_wb_data  = 0;
    foreach (inflight[i]) begin
      if (inflight[i].age == DEPTH-1 && inflight[i].we && inflight[i].rd != 0 &&
          (inflight[i].ready || res_valid_i[DEPTH-1])) begin
        exp_wb_valid = 1;
        exp_wb_rd    = inflight[i].rd;
        exp_wb_data  = res_valid_i[DEPTH-1] ? res_data_i[(DEPTH-1)*XLEN +: XLEN]
                                            : inflight[i].data;
      end
    end
  endfunction

  // Advance the model by one clock edge using the inputs of that cycle.
  function automatic void modelStep();
    inst_t nxt[$];
    if (reset_i) begin
      inflight.delete();
      m_err = 0;
      return;
    end
    foreach (inflight[i]) begin
      inst_t it = inflight[i];
      if (it.age == DEPTH-1 && it.we && !it.ready && !res_valid_i[DEPTH-1]) m_err = 1;
      if (res_valid_i[it.age]) begin
        it.ready = 1;
        it.data  = res_data_i[it.age*XLEN +: XLEN];
      end
      if (it.age != DEPTH-1 && !(flush_i && it.age == 0)) begin
        it.age++;
        nxt.push_back(it);
      end
    end
    if (issue_valid_i && !exp_stall && !flush_i) begin
      inst_t n;
      n.age = 0; n.we = issue_we_i; n.rd = issue_rd_i; n.ready = 0; n.data = '0;
      nxt.push_back(n);
    end
    inflight = nxt;
  endfunction

  task automatic checkOutput();
    for (int p = 0; p < NRD; p++) begin
      if (exp_def[p]) chk($sformatf("opnd[%0d]", p), 64'(opnd_o[p*XLEN +: XLEN]), 64'(exp_opnd[p]));
    end
    chk("stall", 64'(stall_o), 64'(exp_stall));
    chk("wb_valid", 64'(wb_valid_o), 64'(exp_wb_valid));
    chk("wb_rd", 64'(wb_rd_o), 64'(exp_wb_rd));
    chk("wb_data", 64'(wb_data_o), 64'(exp_wb_data));
    chk("err", 64'(err_o), 64'(m_err));
  endtask

  // Drive one cycle of inputs away from the rising edge, then check.
  task automatic applyStimulus(input bit rst, input bit v, input bit we, input bit [4:0] rd,
                               input bit [4:0] rs0, input bit [4:0] rs1,
                               input bit [NRD*XLEN-1:0] rf, input bit [DEPTH-1:0] rv,
                               input bit [DEPTH*XLEN-1:0] rdat, input bit fl);
    @(negedge clk);
    reset_i       = rst;
    issue_valid_i = v;
    issue_we_i    = we;
    issue_rd_i    = rd;
    issue_rs_i    = {rs1, rs0};
    rf_data_i     = rf;
    res_valid_i   = rv;
    res_data_i    = rdat;
    flush_i       = fl;
    #1;
    modelOutputs();
    checkOutput();
  endtask

  task automatic advance();
    @(posedge clk);
    modelStep();
  endtask

  localparam bit [NRD*XLEN-1:0]   RF  = {32'h2222_2222, 32'h0000_CAFE};
  localparam bit [DEPTH*XLEN-1:0] RD0 = '0;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit [DEPTH-1:0] rv;
    reset_i = 1; issue_valid_i = 0; issue_we_i = 0; issue_rd_i = 0; issue_rs_i = 0;
    rf_data_i = 0; res_valid_i = 0; res_data_i = 0; flush_i = 0;
    @(posedge clk);
    @(posedge clk);
    modelStep();

    // First cycle after reset: register-file values, nothing pending.
    applyStimulus(0, 1, 0, 0, 5'd12, 5'd0, {32'h2222, 32'h1111}, 0, RD0, 0);
    chk("lit_rst_opnd0", 64'(opnd_o[XLEN-1:0]), 64'h1111);
    chk("lit_rst_opnd1", 64'(opnd_o[2*XLEN-1:XLEN]), 64'h0);
    chk("lit_rst_stall", 64'(stall_o), 64'h0);
    chk("lit_rst_wb", 64'(wb_valid_o), 64'h0);
    chk("lit_rst_err", 64'(err_o), 64'h0);
    advance();

`ifdef BYPASS_PIPELINE_BYPASS_EN
    // x5 <- 0x11 produced in EX, read the very next cycle.
    applyStimulus(0, 1, 1, 5, 0, 0, RF, 0, RD0, 0); advance();
    applyStimulus(0, 1, 0, 0, 5, 0, RF, 3'b001, {32'h0, 32'h0, 32'h11}, 0);
    chk("lit_fwd_opnd", 64'(opnd_o[XLEN-1:0]), 64'h11);
    chk("lit_fwd_stall", 64'(stall_o), 64'h0);
    advance();
    // Load-use on x7: one stall, then the MEM result forwarded.
    applyStimulus(0, 1, 1, 7, 0, 0, RF, 0, RD0, 0); advance();
    applyStimulus(0, 1, 0, 0, 7, 0, RF, 0, RD0, 0);
    chk("lit_lu_stall1", 64'(stall_o), 64'h1);
    advance();
    applyStimulus(0, 1, 0, 0, 7, 0, RF, 3'b010, {32'h0, 32'h77, 32'h0}, 0);
    chk("lit_lu_stall2", 64'(stall_o), 64'h0);
    chk("lit_lu_opnd", 64'(opnd_o[XLEN-1:0]), 64'h77);
    advance();
    // Two writers of x3: the younger one (0xB) wins.
    applyStimulus(0, 1, 1, 3, 0, 0, RF, 0, RD0, 0); advance();
    applyStimulus(0, 1, 1, 3, 0, 0, RF, 3'b001, {32'h0, 32'h0, 32'hA}, 0); advance();
    applyStimulus(0, 1, 0, 0, 3, 0, RF, 3'b001, {32'h0, 32'h0, 32'hB}, 0);
    chk("lit_young_opnd", 64'(opnd_o[XLEN-1:0]), 64'hB);
    advance();
`else
    // x5 <- 0x11 then read x5: stalls while x5 is in flight, then RF.
    applyStimulus(0, 1, 1, 5, 0, 0, RF, 0, RD0, 0); advance();
    applyStimulus(0, 1, 0, 0, 5, 0, RF, 3'b001, {32'h0, 32'h0, 32'h11}, 0);
    chk("lit_nb_stall1", 64'(stall_o), 64'h1);
    advance();
    applyStimulus(0, 1, 0, 0, 5, 0, RF, 0, RD0, 0);
    chk("lit_nb_stall2", 64'(stall_o), 64'h1);
    advance();
    applyStimulus(0, 1, 0, 0, 5, 0, RF, 0, RD0, 0);
    chk("lit_nb_stall3", 64'(stall_o), 64'h1);
    chk("lit_nb_wb_valid", 64'(wb_valid_o), 64'h1);
    chk("lit_nb_wb_rd", 64'(wb_rd_o), 64'h5);
    chk("lit_nb_wb_data", 64'(wb_data_o), 64'h11);
    advance();
    applyStimulus(0, 1, 0, 0, 5, 0, RF, 0, RD0, 0);
    chk("lit_nb_stall4", 64'(stall_o), 64'h0);
    chk("lit_nb_opnd", 64'(opnd_o[XLEN-1:0]), 64'hCAFE);
    advance();
`endif

    // Writes and reads of x0: never stall, read as zero, never written.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 1, 0, 0, 0, RF, '1, {32'h5, 32'h6, 32'h7}, 0);
      chk("lit_x0_stall", 64'(stall_o), 64'h0);
      chk("lit_x0_opnd", 64'(opnd_o[XLEN-1:0]), 64'h0);
      chk("lit_x0_wb", 64'(wb_valid_o), 64'h0);
      advance();
    end

    // Flushed write to x9 never reaches the register file.
    applyStimulus(0, 1, 1, 9, 0, 0, RF, 0, RD0, 0); advance();
    applyStimulus(0, 0, 0, 0, 0, 0, RF, 0, RD0, 1); advance();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 0, 9, 0, RF, '1, {32'h99, 32'h99, 32'h99}, 0);
      chk("lit_fl_stall", 64'(stall_o), 64'h0);
      chk("lit_fl_opnd", 64'(opnd_o[XLEN-1:0]), 64'hCAFE);
      chk("lit_fl_wb", 64'(wb_valid_o), 64'h0);
      advance();
    end

    // Withheld result for x4: err rises once it has passed WB, and sticks.
    applyStimulus(0, 1, 1, 4, 0, 0, RF, 0, RD0, 0); advance();
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, RF, 0, RD0, 0);
      chk($sformatf("lit_err_c%0d", i), 64'(err_o), (i >= DEPTH + 1) ? 64'h1 : 64'h0);
      advance();
    end
    applyStimulus(1, 0, 0, 0, 0, 0, RF, 0, RD0, 0); advance();
    applyStimulus(0, 0, 0, 0, 0, 0, RF, 0, RD0, 0);
    chk("lit_err_cleared", 64'(err_o), 64'h0);
    advance();

    // Randomized run over a small register range to provoke hazards.
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < DEPTH; k++) rv[k] = ($urandom_range(0, 7) != 0);
      applyStimulus($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
                    1'($urandom), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    {$urandom, $urandom}, rv, {$urandom, $urandom, $urandom},
                    $urandom_range(0, 15) == 0);
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
